// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: in_op encodings, FSM
// state enum and the default operand width.
package mdu_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on unsigned magnitudes.
// Ports:
//   rem_i / quo_i : partial remainder and partially shifted dividend/quotient
//   div_i         : divisor magnitude
//   rem_o / quo_o : remainder and quotient after one more quotient bit
module mdu_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] div_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // rem_i < div_i always holds, so the MSB of diff is a clean borrow flag.
  always_comb begin
    shifted = {rem_i, quo_i[DATA_W-1]};
    diff    = shifted - {1'b0, div_i};
    if (diff[DATA_W]) begin
      rem_o = shifted[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end else begin
      rem_o = diff[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with HI/LO registers. Iterative shift-add
// multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
// Optional macro MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle combinational
// multiply instead of the iterative MUL state.
// Ports:
//   in_clk, in_rst        : clock, synchronous active-high reset
//   in_start, in_op       : MDU instruction valid and its opcode
//   in_rs_data, in_rt_data: operands (rs also feeds MTHI/MTLO)
//   in_rd_req             : MFHI/MFLO in EX this cycle
//   out_stall             : combinational pipeline freeze
//   out_busy, out_done    : operation in progress / HI-LO written pulse
//   out_hi, out_lo        : architectural HI and LO
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_start,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic              in_rd_req,
  output logic              out_stall,
  output logic              out_busy,
  output logic              out_done,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  mdu_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*DATA_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]       opb_q, opb_d;
  logic                    neg_res_q, neg_res_d;
  logic                    neg_rem_q, neg_rem_d;
  logic                    is_div_q, is_div_d;
  logic                    div0_q, div0_d;
  logic [DATA_W-1:0]       hi_q, hi_d;
  logic [DATA_W-1:0]       lo_q, lo_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    op_signed;
  logic [DATA_W-1:0]       rs_mag, rt_mag;
  logic [DATA_W:0]         mul_sum;
  logic [2*DATA_W-1:0]     mul_next;
  logic [2*DATA_W-1:0]     prod_fix;
  logic [DATA_W-1:0]       quo_fix, rem_fix;
  logic [DATA_W-1:0]       div_rem, div_quo;

  // Divide datapath: acc holds {remainder, dividend/quotient}.
  mdu_div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem_i (acc_q[2*DATA_W-1:DATA_W]),
    .quo_i (acc_q[DATA_W-1:0]),
    .div_i (opb_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  // Operand magnitudes; negating the most-negative value yields its
  // correct unsigned magnitude.
  always_comb begin
    op_signed = (in_op == OP_MULT) || (in_op == OP_DIV);
    rs_mag    = (op_signed && in_rs_data[DATA_W-1]) ? -in_rs_data : in_rs_data;
    rt_mag    = (op_signed && in_rt_data[DATA_W-1]) ? -in_rt_data : in_rt_data;
  end

  // Shift-add multiply step: acc holds {partial product, remaining multiplier}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opb_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[DATA_W-1:1]} : {1'b0, acc_q[2*DATA_W-1:1]};
  end

  // Sign fix-up applied in FIX.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          unique case (in_op)
            OP_MULT, OP_MULTU: begin
              neg_res_d = op_signed && (in_rs_data[DATA_W-1] ^ in_rt_data[DATA_W-1]);
              neg_rem_d = 1'b0;
              is_div_d  = 1'b0;
              div0_d    = 1'b0;
              cnt_d     = '0;
`ifdef MDU_FAST_MUL_EN
              acc_d     = {{DATA_W{1'b0}}, rs_mag} * {{DATA_W{1'b0}}, rt_mag};
              state_d   = ST_FIX;
`else
              acc_d     = {{DATA_W{1'b0}}, rt_mag};
              opb_d     = rs_mag;
              state_d   = ST_MUL;
`endif
            end
            OP_DIV, OP_DIVU: begin
              neg_res_d = op_signed && (in_rs_data[DATA_W-1] ^ in_rt_data[DATA_W-1]);
              neg_rem_d = op_signed && in_rs_data[DATA_W-1];
              is_div_d  = 1'b1;
              cnt_d     = '0;
              opb_d     = rt_mag;
              // Divide by zero keeps the raw dividend for HI and skips DIV.
              if (in_rt_data == '0) begin
                div0_d  = 1'b1;
                acc_d   = {{DATA_W{1'b0}}, in_rs_data};
                state_d = ST_FIX;
              end else begin
                div0_d  = 1'b0;
                acc_d   = {{DATA_W{1'b0}}, rs_mag};
                state_d = ST_DIV;
              end
            end
            OP_MTHI: hi_d = in_rs_data;
            OP_MTLO: lo_d = in_rs_data;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_FIX;
      end
      ST_DIV: begin
        acc_d = {div_rem, div_quo};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (div0_q) begin
          hi_d = acc_q[DATA_W-1:0];
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIX);
  end

  // State and output registers.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out_busy  = busy_q;
  assign out_done  = done_q;
  assign out_hi    = hi_q;
  assign out_lo    = lo_q;
  assign out_stall = busy_q & (in_start | in_rd_req);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (DATA_W = 32).
module tb_mdu_ctrl;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        in_clk;
  logic        in_rst;
  logic        in_start;
  logic [2:0]  in_op;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic        in_rd_req;
  logic        out_stall;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_hi;
  logic [31:0] out_lo;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_ctrl #(.DATA_W(32)) dut (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_start   (in_start),
    .in_op      (in_op),
    .in_rs_data (in_rs_data),
    .in_rt_data (in_rt_data),
    .in_rd_req  (in_rd_req),
    .out_stall  (out_stall),
    .out_busy   (out_busy),
    .out_done   (out_done),
    .out_hi     (out_hi),
    .out_lo     (out_lo)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one MULT/DIV-class op from just after a rising edge; checks
  // latency, busy length, HI/LO hold while busy and final HI/LO.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input int exp_lat,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    int busy_cyc;
    bit hold_bad;
    lat = 0; busy_cyc = 0; hold_bad = 0;
    in_start = 1'b1; in_op = op; in_rs_data = rs; in_rt_data = rt;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(negedge in_clk);
      if (out_busy) busy_cyc++;
      if (out_hi !== m_hi || out_lo !== m_lo) hold_bad = 1;
      if (out_done) lat = k;
      else begin
        @(posedge in_clk); #1;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_cyc), 64'(exp_lat));
    check({tag, "_hold"}, 64'(hold_bad), 64'd0);
    @(posedge in_clk); #1;
    @(negedge in_clk);
    check({tag, "_hilo"}, {out_hi, out_lo}, {exp_hi, exp_lo});
    check({tag, "_idle"}, {62'd0, out_busy, out_done}, 64'd0);
    m_hi = exp_hi; m_lo = exp_lo;
    @(posedge in_clk); #1;
  endtask

  // MTHI/MTLO/reserved: single-cycle, never busy.
  task automatic do_mt(input string tag, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    in_start = 1'b1; in_op = op; in_rs_data = rs;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    @(negedge in_clk);
    check({tag, "_hilo"}, {out_hi, out_lo}, {exp_hi, exp_lo});
    check({tag, "_flags"}, {62'd0, out_busy, out_done}, 64'd0);
    m_hi = exp_hi; m_lo = exp_lo;
    @(posedge in_clk); #1;
  endtask

  initial begin
    bit stall_bad, hold_bad, post_bad;

    // Reset with a competing MTHI and MFHI request.
    in_rst = 1'b1; in_start = 1'b1; in_op = OP_MTHI; in_rs_data = 32'hDEAD;
    in_rt_data = '0; in_rd_req = 1'b1;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    check("rst_hilo", {out_hi, out_lo}, 64'd0);
    check("rst_flags", {61'd0, out_busy, out_done, out_stall}, 64'd0);
    @(posedge in_clk); #1;
    in_rst = 1'b0; in_start = 1'b0; in_rd_req = 1'b0;
    @(negedge in_clk);
    check("rst_prio_hi", 64'(out_hi), 64'd0);
    @(posedge in_clk); #1;

    do_op("divu_100_7",  OP_DIVU,  32'd100,      32'd7,        DIV_LAT, 32'd2,        32'd14);
    do_op("div_m7_2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("mult_m1_2",   OP_MULT,  32'hFFFFFFFF, 32'd2,        MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_op("multu_m1_2",  OP_MULTU, 32'hFFFFFFFF, 32'd2,        MUL_LAT, 32'h00000001, 32'hFFFFFFFE);
    do_op("divu_by0",    OP_DIVU,  32'h1234,     32'd0,        1,       32'h1234,     32'hFFFFFFFF);
    do_op("div_neg_by0", OP_DIV,   32'hFFFFFFF0, 32'd0,        1,       32'hFFFFFFF0, 32'hFFFFFFFF);
    do_op("div_min_m1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h00000000, 32'h80000000);
    do_op("mult_min_sq", OP_MULT,  32'h80000000, 32'h80000000, MUL_LAT, 32'h40000000, 32'h00000000);
    do_op("mult_7_m3",   OP_MULT,  32'd7,        32'hFFFFFFFD, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB);

    do_mt("mthi", OP_MTHI, 32'h11111111, 32'h11111111, m_lo);
    do_mt("mtlo", OP_MTLO, 32'h22222222, m_hi, 32'h22222222);
    do_mt("rsvd6", 3'd6, 32'h55555555, m_hi, m_lo);
    do_mt("rsvd7", 3'd7, 32'h66666666, m_hi, m_lo);

    // Stall: DIV 100/7 at T, MFHI from T+5, MTLO 0x77 from T+10 until accepted.
    stall_bad = 0; hold_bad = 0;
    in_start = 1'b1; in_op = OP_DIV; in_rs_data = 32'd100; in_rt_data = 32'd7;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      in_rd_req = (c >= 5 && c <= 34);
      in_start  = (c >= 10 && c <= 34);
      in_op = OP_MTLO; in_rs_data = 32'h77;
      @(negedge in_clk);
      if (c >= 5 && c <= 33 && out_stall !== 1'b1) stall_bad = 1;
      if (c >= 1 && c <= 33 && out_lo !== m_lo) hold_bad = 1;
      if (c == 34) begin
        check("stall_low_t34", 64'(out_stall), 64'd0);
        check("stall_lo_t34", 64'(out_lo), 64'd14);
        check("stall_hi_t34", 64'(out_hi), 64'd2);
      end
      if (c == 35) check("stall_mtlo_t35", 64'(out_lo), 64'h77);
      @(posedge in_clk); #1;
    end
    in_start = 1'b0; in_rd_req = 1'b0;
    check("stall_window", 64'(stall_bad), 64'd0);
    check("stall_lo_hold", 64'(hold_bad), 64'd0);
    m_hi = 32'd2; m_lo = 32'h77;

    // Reset at T+10 of a MULT aborts it.
    in_start = 1'b1; in_op = OP_MULT; in_rs_data = 32'hFFFFFFFF; in_rt_data = 32'd2;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    repeat (9) begin @(posedge in_clk); #1; end
    in_rst = 1'b1;
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    @(negedge in_clk);
    check("abort_flags", {62'd0, out_busy, out_done}, 64'd0);
    check("abort_hilo", {out_hi, out_lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    post_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge in_clk); #1;
      @(negedge in_clk);
      if (out_done !== 1'b0 || out_busy !== 1'b0 || out_hi !== 32'd0 || out_lo !== 32'd0) post_bad = 1;
    end
    check("abort_no_done", 64'(post_bad), 64'd0);
    @(posedge in_clk); #1;
    do_mt("mtlo_a5", OP_MTLO, 32'hA5, 32'd0, 32'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
